fpu_wb_queue: RTL and testbench

FPU_WB_QUEUE -- requirements
Module: fpu_wb_queue

---
 rtl/fpu_wb_queue.sv | 150 +++++++++++++++
 tb/tb_fpu_wb_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_wb_queue.sv
// FPU writeback queue.
// Tracks FPU operations from issue to register-file writeback through two
// in-order FIFOs: a tag FIFO {rd, setz} for ops issued but not yet completed,
// and a result FIFO {rd, setz, data} for completed ops waiting for a free
// register-file write port. Issue credit covers both FIFOs together, so the
// result FIFO cannot overflow.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   iss_valid/rd/setz     issue request from stage 2
//   iss_full              no issue credit, stage 2 must stall
//   fpu_done, fpu_result  FPU completion pulse and result word
//   flush                 synchronous discard of all pending ops
//   wb_valid/rd/data/setz/z  head of the result FIFO
//   wb_ready              register-file port free, pops the head
//   busy_mask             one bit per register targeted by any pending op
//   err                   sticky: [0] issue while full, [1] done with no tag
module fpu_wb_queue #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iss_valid,
  input  logic [3:0]  iss_rd,
  input  logic        iss_setz,
  output logic        iss_full,
  input  logic        fpu_done,
  input  logic [15:0] fpu_result,
  input  logic        flush,
  output logic        wb_valid,
  output logic [3:0]  wb_rd,
  output logic [15:0] wb_data,
  output logic        wb_setz,
  output logic        wb_z,
  input  logic        wb_ready,
  output logic [15:0] busy_mask,
  output logic [1:0]  err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [3:0]    tag_rd_q   [DEPTH];
  logic          tag_setz_q [DEPTH];
  logic [3:0]    res_rd_q   [DEPTH];
  logic          res_setz_q [DEPTH];
  logic [15:0]   res_data_q [DEPTH];

  logic [PW-1:0] tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  logic [PW-1:0] res_wp_q, res_wp_d, res_rp_q, res_rp_d;
  logic [CW-1:0] tag_cnt_q, tag_cnt_d, res_cnt_q, res_cnt_d;
  logic [1:0]    err_q, err_d;

  logic          tag_push, tag_pop, res_push, res_pop;
  logic [CW:0]   total_cnt;
  logic [15:0]   head_data;

  always_comb begin
    total_cnt = {1'b0, tag_cnt_q} + {1'b0, res_cnt_q};
    iss_full  = total_cnt >= (CW + 1)'(DEPTH);
    wb_valid  = res_cnt_q != '0;

    // Flush overrides every same-cycle transfer.
    tag_push  = iss_valid & ~iss_full & ~flush;
    tag_pop   = fpu_done & (tag_cnt_q != '0) & ~flush;
    res_push  = tag_pop;
    res_pop   = wb_valid & wb_ready & ~flush;

    // Illegal requests are still flagged during flush.
    err_d     = err_q | {fpu_done & (tag_cnt_q == '0), iss_valid & iss_full};

    // Head outputs are forced to zero while the result FIFO is empty.
    head_data = res_data_q[res_rp_q];
    wb_rd     = wb_valid ? res_rd_q[res_rp_q]   : 4'h0;
    wb_setz   = wb_valid ? res_setz_q[res_rp_q] : 1'b0;
    wb_data   = wb_valid ? head_data            : 16'h0000;
    wb_z      = wb_valid & (head_data == 16'h0000);
  end

  always_comb begin
    tag_wp_d  = tag_push ? tag_wp_q + PW'(1) : tag_wp_q;
    tag_rp_d  = tag_pop  ? tag_rp_q + PW'(1) : tag_rp_q;
    res_wp_d  = res_push ? res_wp_q + PW'(1) : res_wp_q;
    res_rp_d  = res_pop  ? res_rp_q + PW'(1) : res_rp_q;
    tag_cnt_d = tag_cnt_q;
    res_cnt_d = res_cnt_q;
    if (tag_push && !tag_pop) tag_cnt_d = tag_cnt_q + CW'(1);
    if (!tag_push && tag_pop) tag_cnt_d = tag_cnt_q - CW'(1);
    if (res_push && !res_pop) res_cnt_d = res_cnt_q + CW'(1);
    if (!res_push && res_pop) res_cnt_d = res_cnt_q - CW'(1);
    if (flush) begin
      tag_wp_d  = '0;
      tag_rp_d  = '0;
      res_wp_d  = '0;
      res_rp_d  = '0;
      tag_cnt_d = '0;
      res_cnt_d = '0;
    end
  end

  // An entry at slot i is live when its distance from the read pointer is
  // below the occupancy count.
  always_comb begin
    busy_mask = 16'h0000;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ({1'b0, PW'(i) - tag_rp_q} < tag_cnt_q) begin
        busy_mask = busy_mask | (16'h0001 << tag_rd_q[i]);
      end
      if ({1'b0, PW'(i) - res_rp_q} < res_cnt_q) begin
        busy_mask = busy_mask | (16'h0001 << res_rd_q[i]);
      end
    end
  end

  assign err = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_wp_q  <= '0;
      tag_rp_q  <= '0;
      res_wp_q  <= '0;
      res_rp_q  <= '0;
      tag_cnt_q <= '0;
      res_cnt_q <= '0;
      err_q     <= 2'b00;
    end else begin
      tag_wp_q  <= tag_wp_d;
      tag_rp_q  <= tag_rp_d;
      res_wp_q  <= res_wp_d;
      res_rp_q  <= res_rp_d;
      tag_cnt_q <= tag_cnt_d;
      res_cnt_q <= res_cnt_d;
      err_q     <= err_d;
    end
  end

  // Payload storage needs no reset: validity comes from the counts alone.
  always_ff @(posedge clk) begin
    if (tag_push) begin
      tag_rd_q[tag_wp_q]   <= iss_rd;
      tag_setz_q[tag_wp_q] <= iss_setz;
    end
    if (res_push) begin
      res_rd_q[res_wp_q]   <= tag_rd_q[tag_rp_q];
      res_setz_q[res_wp_q] <= tag_setz_q[tag_rp_q];
      res_data_q[res_wp_q] <= fpu_result;
    end
  end

endmodule

// File: tb/tb_fpu_wb_queue.sv
module tb_fpu_wb_queue;

  typedef struct {
    logic        iv;
    logic [3:0]  ird;
    logic        isz;
    logic        dn;
    logic [15:0] res;
    logic        fl;
    logic        rdy;
    logic        ev;
    logic [3:0]  erd;
    logic [15:0] edata;
    logic        esz;
    logic        ez;
    logic [15:0] ebusy;
    logic        efull;
    logic [1:0]  eerr;
  } vec_t;

  logic        clk, reset;
  logic        iss_valid, iss_setz, fpu_done, flush, wb_ready;
  logic [3:0]  iss_rd;
  logic [15:0] fpu_result;

  logic        iss_full, wb_valid, wb_setz, wb_z;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data, busy_mask;
  logic [1:0]  err;

  logic        iss_full4, wb_valid4, wb_setz4, wb_z4;
  logic [3:0]  wb_rd4;
  logic [15:0] wb_data4, busy_mask4;
  logic [1:0]  err4;

  int checks = 0;
  int errors = 0;

  vec_t tbl2 [20];
  vec_t tbl4 [5];

  fpu_wb_queue #(.DEPTH(2)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .iss_setz   (iss_setz),
    .iss_full   (iss_full),
    .fpu_done   (fpu_done),
    .fpu_result (fpu_result),
    .flush      (flush),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_setz    (wb_setz),
    .wb_z       (wb_z),
    .wb_ready   (wb_ready),
    .busy_mask  (busy_mask),
    .err        (err)
  );

  // Deeper instance: lets issue, done and pop all land on one edge.
  fpu_wb_queue #(.DEPTH(4)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .iss_setz   (iss_setz),
    .iss_full   (iss_full4),
    .fpu_done   (fpu_done),
    .fpu_result (fpu_result),
    .flush      (flush),
    .wb_valid   (wb_valid4),
    .wb_rd      (wb_rd4),
    .wb_data    (wb_data4),
    .wb_setz    (wb_setz4),
    .wb_z       (wb_z4),
    .wb_ready   (wb_ready),
    .busy_mask  (busy_mask4),
    .err        (err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic iv, input logic [3:0] ird, input logic isz,
    input logic dn, input logic [15:0] res, input logic fl, input logic rdy,
    input logic ev, input logic [3:0] erd, input logic [15:0] edata,
    input logic esz, input logic ez, input logic [15:0] ebusy,
    input logic efull, input logic [1:0] eerr);
    vec_t v;
    v.iv = iv;   v.ird = ird;     v.isz = isz; v.dn = dn; v.res = res;
    v.fl = fl;   v.rdy = rdy;     v.ev = ev;   v.erd = erd;
    v.edata = edata; v.esz = esz; v.ez = ez;   v.ebusy = ebusy;
    v.efull = efull; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_rd = 4'h0; iss_setz = 1'b0;
    fpu_done = 1'b0; fpu_result = 16'h0000; flush = 1'b0; wb_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input bit sel4, input int idx);
    logic        a_v, a_sz, a_z, a_full;
    logic [3:0]  a_rd;
    logic [15:0] a_data, a_busy;
    logic [1:0]  a_err;
    string       tag;
    iss_valid = v.iv; iss_rd = v.ird; iss_setz = v.isz;
    fpu_done = v.dn; fpu_result = v.res; flush = v.fl; wb_ready = v.rdy;
    @(posedge clk);
    #1;
    if (sel4) begin
      a_v = wb_valid4; a_rd = wb_rd4; a_data = wb_data4; a_sz = wb_setz4;
      a_z = wb_z4; a_busy = busy_mask4; a_full = iss_full4; a_err = err4;
    end else begin
      a_v = wb_valid; a_rd = wb_rd; a_data = wb_data; a_sz = wb_setz;
      a_z = wb_z; a_busy = busy_mask; a_full = iss_full; a_err = err;
    end
    tag = $sformatf("%s row%0d", sel4 ? "d4" : "d2", idx);
    chk({tag, " wb_valid"}, 32'(a_v), 32'(v.ev));
    if (v.ev) begin
      chk({tag, " wb_rd"},   32'(a_rd),   32'(v.erd));
      chk({tag, " wb_data"}, 32'(a_data), 32'(v.edata));
      chk({tag, " wb_setz"}, 32'(a_sz),   32'(v.esz));
      chk({tag, " wb_z"},    32'(a_z),    32'(v.ez));
    end
    chk({tag, " busy_mask"}, 32'(a_busy), 32'(v.ebusy));
    chk({tag, " iss_full"},  32'(a_full), 32'(v.efull));
    chk({tag, " err"},       32'(a_err),  32'(v.eerr));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " wb_valid"},  32'(wb_valid),  32'h0);
    chk({tag, " wb_rd"},     32'(wb_rd),     32'h0);
    chk({tag, " wb_data"},   32'(wb_data),   32'h0);
    chk({tag, " wb_setz"},   32'(wb_setz),   32'h0);
    chk({tag, " wb_z"},      32'(wb_z),      32'h0);
    chk({tag, " busy_mask"}, 32'(busy_mask), 32'h0);
    chk({tag, " iss_full"},  32'(iss_full),  32'h0);
    chk({tag, " err"},       32'(err),       32'h0);
  endtask

  initial begin
    //                iv ird isz dn res       fl rdy  ev erd edata     esz ez busy      full err
    // single op, one-cycle writeback
    tbl2[0]  = mk(1, 3, 1, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 16'h0008, 0, 2'b00);
    tbl2[1]  = mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 16'h0008, 0, 2'b00);
    tbl2[2]  = mk(0, 0, 0, 1, 16'h4780, 0, 1, 1, 3, 16'h4780, 1, 0, 16'h0008, 0, 2'b00);
    tbl2[3]  = mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 2'b00);
    // credit exhaustion, ignored issue, backpressure, in-order drain
    tbl2[4]  = mk(1, 1, 1, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0002, 0, 2'b00);
    tbl2[5]  = mk(1, 2, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0006, 1, 2'b00);
    tbl2[6]  = mk(1, 7, 1, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0006, 1, 2'b01);
    tbl2[7]  = mk(0, 0, 0, 1, 16'h0000, 0, 0, 1, 1, 16'h0000, 1, 1, 16'h0006, 1, 2'b01);
    tbl2[8]  = mk(0, 0, 0, 1, 16'h1234, 0, 0, 1, 1, 16'h0000, 1, 1, 16'h0006, 1, 2'b01);
    tbl2[9]  = mk(0, 0, 0, 0, 16'h0000, 0, 1, 1, 2, 16'h1234, 0, 0, 16'h0004, 0, 2'b01);
    tbl2[10] = mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 2'b01);
    // same rd twice, issue and done on one edge; bit stays until last pops
    tbl2[11] = mk(1, 9, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0200, 0, 2'b01);
    tbl2[12] = mk(1, 9, 1, 1, 16'h00AA, 0, 0, 1, 9, 16'h00AA, 0, 0, 16'h0200, 1, 2'b01);
    tbl2[13] = mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 16'h0200, 0, 2'b01);
    tbl2[14] = mk(0, 0, 0, 1, 16'h8000, 0, 0, 1, 9, 16'h8000, 1, 0, 16'h0200, 0, 2'b01);
    tbl2[15] = mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 2'b01);
    // flush with two pending plus same-cycle done, then a stray done
    tbl2[16] = mk(1, 2, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0004, 0, 2'b01);
    tbl2[17] = mk(1, 3, 1, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h000C, 1, 2'b01);
    tbl2[18] = mk(0, 0, 0, 1, 16'h5555, 1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 2'b01);
    tbl2[19] = mk(0, 0, 0, 1, 16'h1111, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 2'b11);

    // DEPTH=4: issue + done + pop on one edge
    tbl4[0]  = mk(1, 4, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0010, 0, 2'b00);
    tbl4[1]  = mk(1, 6, 1, 1, 16'h00AA, 0, 0, 1, 4, 16'h00AA, 0, 0, 16'h0050, 0, 2'b00);
    tbl4[2]  = mk(1, 5, 0, 1, 16'h0000, 0, 1, 1, 6, 16'h0000, 1, 1, 16'h0060, 0, 2'b00);
    tbl4[3]  = mk(0, 0, 0, 1, 16'h0101, 0, 1, 1, 5, 16'h0101, 0, 0, 16'h0020, 0, 2'b00);
    tbl4[4]  = mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 2'b00);

    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) run_vec(tbl2[i], 1'b0, i);

    idle();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) run_vec(tbl4[i], 1'b1, i);

    // Asynchronous reset between edges with work pending.
    idle();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    iss_valid = 1'b1; iss_rd = 4'd3; iss_setz = 1'b1;
    @(posedge clk);
    #1;
    iss_rd = 4'd4; fpu_done = 1'b1; fpu_result = 16'h1234;
    @(posedge clk);
    #1;
    idle();
    chk("midop pre wb_valid", 32'(wb_valid), 32'h1);
    chk("midop pre busy_mask", 32'(busy_mask), 32'h0018);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    chk("async_reset d4 busy_mask", 32'(busy_mask4), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    fpu_done = 1'b1; fpu_result = 16'h0007;
    @(posedge clk);
    #1;
    idle();
    chk("post_reset err", 32'(err), 32'h2);
    chk("post_reset wb_valid", 32'(wb_valid), 32'h0);
    chk("post_reset busy_mask", 32'(busy_mask), 32'h0);
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
